zero_one_scan_ctrl: RTL and testbench

//   Sequences the 8-bit detect_zero_one datapath across a wide word, one byte per clock.

---
 rtl/zero_one_scan_ctrl_if.sv | 36 +++
 rtl/zero_one_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_zero_one_scan_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/zero_one_scan_ctrl_if.sv
// zero_one_scan_ctrl_if
//   Request/result bundle between a requester and zero_one_scan_ctrl.
//   master: the requester (drives start/data_in, observes the result)
//   slave : the scan controller (consumes start/data_in, drives the result)
//   Signals:
//     start          scan request, sampled only while the controller is idle
//     data_in        WIDTH-bit word to scan, captured on the accepted start
//     busy           controller is scanning or presenting a result
//     done           one-cycle pulse marking a fresh result
//     all_zero       every examined byte was 8'h00
//     all_one        every examined byte was 8'hFF
//     bytes_scanned  number of bytes examined for the held result
interface zero_one_scan_ctrl_if #(
  parameter int WIDTH = 32
);
  localparam int NBYTES = WIDTH / 8;
  localparam int CW     = $clog2(NBYTES) + 1;

  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic             all_zero;
  logic             all_one;
  logic [CW-1:0]    bytes_scanned;

  modport master (
    output start, data_in,
    input  busy, done, all_zero, all_one, bytes_scanned
  );

  modport slave (
    input  start, data_in,
    output busy, done, all_zero, all_one, bytes_scanned
  );
endinterface

// File: rtl/zero_one_scan_ctrl.sv
// detect_zero_one
//   8-bit zero / all-ones detector shared by the scan controller.
//   x     in   8  byte under test
//   zero  out  1  x == 8'h00
//   one   out  1  x == 8'hFF
module detect_zero_one (
  input  logic [7:0] x,
  output logic       zero,
  output logic       one
);
  assign zero = (x == 8'h00);
  assign one  = &x;
endmodule

// zero_one_scan_ctrl
//   Walks a WIDTH-bit word through one 8-bit detect_zero_one, one byte per
//   clock (least significant byte first), and reports whether the whole word
//   was all zeros or all ones.
//   Parameters:
//     WIDTH       scanned word width, multiple of 8 and >= 8
//     EARLY_EXIT  1: stop as soon as neither flag can still end up true
//   Ports:
//     clk    in  single rising-edge clock
//     rst_n  in  asynchronous active-low reset
//     bus    slave side of zero_one_scan_ctrl_if (start/data_in in,
//            busy/done/all_zero/all_one/bytes_scanned out)
module zero_one_scan_ctrl #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  zero_one_scan_ctrl_if.slave  bus
);
  localparam int NBYTES = WIDTH / 8;
  localparam int CW     = $clog2(NBYTES) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);

  generate
    if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
      $error("zero_one_scan_ctrl: WIDTH must be a multiple of 8 and >= 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;

  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    cnt;
  logic             acc_z;
  logic             acc_o;
  logic             det_zero;
  logic             det_one;
  logic             acc_z_next;
  logic             acc_o_next;
  logic             scan_last;

  logic             all_zero_q;
  logic             all_one_q;
  logic [CW-1:0]    bytes_scanned_q;

  // The word is shifted right one byte per SCAN cycle, so the detector
  // always looks at the low byte, which is byte number cnt of the captured word.
  detect_zero_one u_det (
    .x    (shift_reg[7:0]),
    .zero (det_zero),
    .one  (det_one)
  );

  assign acc_z_next = acc_z & det_zero;
  assign acc_o_next = acc_o & det_one;

  // Once both accumulators are clear no later byte can make either flag true,
  // so the remaining bytes are skipped when early exit is enabled.
  assign scan_last = (cnt == LAST_CNT) ||
                     (EARLY_EXIT && !acc_z_next && !acc_o_next);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = SCAN;
      SCAN:    if (scan_last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State-decoded handshake outputs.
  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  // Datapath: capture on accepted start, accumulate during SCAN, and load
  // the held result on the edge that enters DONE. The result registers keep
  // their value through IDLE until the next result or a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg       <= '0;
      cnt             <= '0;
      acc_z           <= 1'b0;
      acc_o           <= 1'b0;
      all_zero_q      <= 1'b0;
      all_one_q       <= 1'b0;
      bytes_scanned_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            shift_reg <= bus.data_in;
            cnt       <= '0;
            acc_z     <= 1'b1;
            acc_o     <= 1'b1;
          end
        end
        SCAN: begin
          shift_reg <= shift_reg >> 8;
          cnt       <= cnt + CW'(1);
          acc_z     <= acc_z_next;
          acc_o     <= acc_o_next;
          if (scan_last) begin
            all_zero_q      <= acc_z_next;
            all_one_q       <= acc_o_next;
            bytes_scanned_q <= cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.all_zero      = all_zero_q;
  assign bus.all_one       = all_one_q;
  assign bus.bytes_scanned = bytes_scanned_q;
endmodule

// File: tb/tb_zero_one_scan_ctrl.sv
// tb_zero_one_scan_ctrl
//   Self-checking bench for zero_one_scan_ctrl at WIDTH=32. Two instances run
//   side by side on the same stimulus, one with early exit and one without.
//   A behavioural model predicts each instance's outputs every cycle; directed
//   cases pin latencies and results to hand-computed values.
module tb_zero_one_scan_ctrl;
  localparam int WIDTH  = 32;
  localparam int NBYTES = WIDTH / 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] data_in = '0;

  int checks = 0;
  int fails  = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  zero_one_scan_ctrl_if #(.WIDTH(WIDTH)) bus_ee ();
  zero_one_scan_ctrl_if #(.WIDTH(WIDTH)) bus_ne ();

  assign bus_ee.start   = start;
  assign bus_ee.data_in = data_in;
  assign bus_ne.start   = start;
  assign bus_ne.data_in = data_in;

  zero_one_scan_ctrl #(.WIDTH(WIDTH), .EARLY_EXIT(1'b1)) dut_ee (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_ee.slave)
  );

  zero_one_scan_ctrl #(.WIDTH(WIDTH), .EARLY_EXIT(1'b0)) dut_ne (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_ne.slave)
  );

  // Compare one value against its expectation and keep the tallies.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
    end
  endtask

  // Word-level reference: examine bytes LSB first, stop at the last byte or,
  // with early exit, at the first point where neither flag can survive.
  function automatic void model_scan(input logic [31:0] w, input bit ee,
                                     output bit az, output bit ao, output int n);
    logic [7:0] b;
    az = 1'b1;
    ao = 1'b1;
    n  = 0;
    for (int k = 0; k < NBYTES; k++) begin
      b  = w[8*k +: 8];
      az = az && (b == 8'h00);
      ao = ao && (b == 8'hFF);
      n  = k + 1;
      if (ee && !az && !ao) break;
    end
  endfunction

  // Transaction-level model per instance (0 = early exit, 1 = full scan).
  // An accepted start keeps the block busy for (bytes examined + 1) cycles;
  // the final busy cycle is the done pulse, when the held result is updated.
  int left    [2];
  bit pend_az [2];
  bit pend_ao [2];
  int pend_n  [2];
  bit held_az [2];
  bit held_ao [2];
  int held_n  [2];

  always @(posedge clk or negedge rst_n) begin
    bit a_z, a_o;
    int a_n;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        left[i]    = 0;
        held_az[i] = 1'b0;
        held_ao[i] = 1'b0;
        held_n[i]  = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (left[i] == 0) begin
          if (start === 1'b1) begin
            model_scan(data_in, (i == 0), a_z, a_o, a_n);
            pend_az[i] = a_z;
            pend_ao[i] = a_o;
            pend_n[i]  = a_n;
            left[i]    = a_n + 1;
          end
        end else begin
          left[i] = left[i] - 1;
          if (left[i] == 1) begin
            held_az[i] = pend_az[i];
            held_ao[i] = pend_ao[i];
            held_n[i]  = pend_n[i];
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model, away from the
  // rising edge. Fields packed as {busy, done, all_zero, all_one, bytes_scanned}.
  always @(negedge clk) begin
    logic [31:0] exp_v, act_v;
    if (cmp_en) begin
      exp_v = {25'd0, (left[0] > 0), (left[0] == 1), held_az[0], held_ao[0], 3'(held_n[0])};
      act_v = {25'd0, bus_ee.busy, bus_ee.done, bus_ee.all_zero, bus_ee.all_one,
               bus_ee.bytes_scanned};
      checkOutput("cycle_early_exit", act_v, exp_v);
      exp_v = {25'd0, (left[1] > 0), (left[1] == 1), held_az[1], held_ao[1], 3'(held_n[1])};
      act_v = {25'd0, bus_ne.busy, bus_ne.done, bus_ne.all_zero, bus_ne.all_one,
               bus_ne.bytes_scanned};
      checkOutput("cycle_full_scan", act_v, exp_v);
    end
  end

  // Present one start pulse; the rising edge inside this task samples it.
  task automatic applyStimulus(input logic [31:0] word);
    @(negedge clk);
    start   = 1'b1;
    data_in = word;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count falling edges after the start edge until each instance shows done.
  task automatic waitDone(output int lat_ee, output int lat_ne);
    lat_ee = -1;
    lat_ne = -1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (bus_ee.done === 1'b1 && lat_ee < 0) lat_ee = i;
      if (bus_ne.done === 1'b1 && lat_ne < 0) lat_ne = i;
      if (lat_ee >= 0 && lat_ne >= 0) break;
    end
  endtask

  // Directed transaction with literal expectations for both instances.
  task automatic runDirected(input string name, input logic [31:0] word,
                             input int lat_ee_exp, input int lat_ne_exp,
                             input bit az_exp, input bit ao_exp,
                             input int n_ee_exp, input int n_ne_exp);
    int lat_ee, lat_ne;
    applyStimulus(word);
    waitDone(lat_ee, lat_ne);
    checkOutput({name, "_latency_ee"}, lat_ee, lat_ee_exp);
    checkOutput({name, "_latency_ne"}, lat_ne, lat_ne_exp);
    checkOutput({name, "_all_zero_ee"}, bus_ee.all_zero, az_exp);
    checkOutput({name, "_all_one_ee"}, bus_ee.all_one, ao_exp);
    checkOutput({name, "_bytes_ee"}, bus_ee.bytes_scanned, n_ee_exp);
    checkOutput({name, "_all_zero_ne"}, bus_ne.all_zero, az_exp);
    checkOutput({name, "_all_one_ne"}, bus_ne.all_one, ao_exp);
    checkOutput({name, "_bytes_ne"}, bus_ne.bytes_scanned, n_ne_exp);
  endtask

  // Random word biased toward the interesting cases: all zero, all ones,
  // and byte mixes of 00/FF that exercise early exit at every position.
  function automatic logic [31:0] genWord();
    logic [31:0] w;
    case ($urandom_range(0, 3))
      0: w = 32'h0000_0000;
      1: w = 32'hFFFF_FFFF;
      2: w = $urandom;
      default: begin
        w = '0;
        for (int k = 0; k < NBYTES; k++) begin
          case ($urandom_range(0, 2))
            0: w[8*k +: 8] = 8'h00;
            1: w[8*k +: 8] = 8'hFF;
            default: w[8*k +: 8] = 8'($urandom);
          endcase
        end
      end
    endcase
    return w;
  endfunction

  initial begin
    bit m_z, m_o;
    int m_n, dones, lat_ee, lat_ne;

    // Pin the reference model to hand-derived results.
    model_scan(32'h0000_00AA, 1'b1, m_z, m_o, m_n);
    checkOutput("model_aa_ee_bytes", m_n, 1);
    model_scan(32'h0000_00AA, 1'b0, m_z, m_o, m_n);
    checkOutput("model_aa_ne_bytes", m_n, 4);
    model_scan(32'hFF00_00FF, 1'b1, m_z, m_o, m_n);
    checkOutput("model_ff00_ee_bytes", m_n, 2);
    model_scan(32'h0000_0000, 1'b1, m_z, m_o, m_n);
    checkOutput("model_zero_flags", {m_z, m_o}, 2'b10);

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_busy", bus_ee.busy, 0);
    checkOutput("reset_done", bus_ee.done, 0);
    checkOutput("reset_flags", {bus_ee.all_zero, bus_ee.all_one}, 0);
    checkOutput("reset_bytes", bus_ne.bytes_scanned, 0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    $display("[TB] directed cases");
    runDirected("zero", 32'h0000_0000, 5, 5, 1'b1, 1'b0, 4, 4);
    runDirected("ones", 32'hFFFF_FFFF, 5, 5, 1'b0, 1'b1, 4, 4);
    runDirected("aa",   32'h0000_00AA, 2, 5, 1'b0, 1'b0, 1, 4);
    runDirected("ff00", 32'hFF00_00FF, 3, 5, 1'b0, 1'b0, 2, 4);

    // Start held high while busy and data_in scrambled after capture.
    $display("[TB] start while busy");
    dones = 0;
    @(negedge clk);
    start   = 1'b1;
    data_in = 32'h0000_0000;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus_ee.done === 1'b1) dones++;
      if (bus_ne.done === 1'b1) begin
        start = 1'b0;
        break;
      end
      data_in = $urandom;
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("busy_start_dones", dones, 1);
    checkOutput("busy_start_all_zero", bus_ee.all_zero, 1);
    checkOutput("busy_start_bytes", bus_ee.bytes_scanned, 4);
    checkOutput("busy_start_not_queued", bus_ee.busy, 0);

    // Reset asserted between edges in the middle of a scan.
    $display("[TB] reset mid-scan");
    applyStimulus(32'h0000_0000);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", bus_ne.busy, 0);
    checkOutput("midrst_done", bus_ne.done, 0);
    checkOutput("midrst_all_zero", bus_ne.all_zero, 0);
    checkOutput("midrst_bytes", bus_ne.bytes_scanned, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_ee.done === 1'b1 || bus_ne.done === 1'b1) dones++;
    end
    checkOutput("midrst_no_done", dones, 0);
    runDirected("after_rst", 32'hFFFF_FFFF, 5, 5, 1'b0, 1'b1, 4, 4);

    // Randomized traffic, model compared every cycle.
    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start   = ($urandom_range(0, 2) == 0);
      data_in = genWord();
    end
    @(negedge clk);
    start = 1'b0;
    waitDone(lat_ee, lat_ne);
    repeat (8) @(negedge clk);
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
